// File: rtl/fds_pipe.sv
// Flushable, clock-enabled data/valid shift pipeline of DEPTH stages with a registered valid-stage count.
// Define FDS_PIPE_TAPS_EN to expose every stage's data (TAPS) and valid flag (TAPV).
module fds_pipe #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 1
) (
   input  logic                           CK,
   input  logic                           RESET,
   input  logic                           CE,
   input  logic                           FLUSH,
   input  logic [WIDTH-1:0]               D,
   input  logic                           DV,
   output logic [WIDTH-1:0]               Q,
   output logic                           QV,
`ifdef FDS_PIPE_TAPS_EN
   output logic [WIDTH*DEPTH-1:0]         TAPS,
   output logic [DEPTH-1:0]               TAPV,
`endif
   output logic [$clog2(DEPTH+1)-1:0]     FILL
);

   localparam int FW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH-1:0] data     = '0;
   logic [DEPTH-1:0]            vld_pipe = '0;
   logic [FW-1:0]               fill_q   = '0;
   logic [DEPTH-1:0]            vld_nxt;
   logic [FW-1:0]               fill_nxt;

   // FILL is the popcount of the flags the edge will load, so it tracks them with no lag
   always_comb begin
      vld_nxt = vld_pipe;
      if (CE) begin
         vld_nxt[0] = DV;
         for (int k = 1; k < DEPTH; k++) vld_nxt[k] = vld_pipe[k-1];
      end
      if (FLUSH) vld_nxt = '0;
      fill_nxt = '0;
      for (int k = 0; k < DEPTH; k++) fill_nxt = fill_nxt + FW'(vld_nxt[k]);
   end

   always_ff @(posedge CK) begin
      if (RESET) begin
         data     <= '0;
         vld_pipe <= '0;
         fill_q   <= '0;
      end else begin
         // flush only kills valids; data keeps moving with CE
         if (CE) begin
            data[0] <= D;
            for (int k = 1; k < DEPTH; k++) data[k] <= data[k-1];
         end
         vld_pipe <= vld_nxt;
         fill_q   <= fill_nxt;
      end
   end

   assign Q    = data[DEPTH-1];
   assign QV   = vld_pipe[DEPTH-1];
   assign FILL = fill_q;

`ifdef FDS_PIPE_TAPS_EN
   assign TAPS = data;
   assign TAPV = vld_pipe;
`endif

endmodule
